// File: rtl/seq_div_pkg.sv
// Shared constants and FSM state type for the sequential signed divider.
package div_pkg;

  localparam int DVD_W    = 32;          // dividend width
  localparam int DVS_W    = 16;          // divisor width
  localparam int QUO_W    = 16;          // quotient / remainder width
  localparam int REM_W    = DVS_W + 1;   // partial remainder keeps one extra bit
  localparam int ITER_CNT = 16;          // one quotient bit per iteration
  localparam int CNT_W    = 4;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ITER_CNT - 1);
  localparam logic [QUO_W-1:0] QUO_POS_MAX = 16'd32767;
  localparam logic [QUO_W-1:0] QUO_NEG_MAX = 16'd32768;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/seq_div_if.sv
// Request/response bundle between a requester and the divider.
// Handshake: a request is accepted on a rising edge where start=1 and the
// divider is idle (busy=0 and done=0); start is ignored at every other edge.
// Operands are captured at that edge only. done pulses for one cycle when
// the results are valid; the results then hold until the next accept.
interface seq_div_if;
  import div_pkg::*;

  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [QUO_W-1:0] quotient;
  logic [QUO_W-1:0] remainder;
  logic             div_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, overflow
  );

endinterface

// File: rtl/seq_div_step.sv
// One restoring division step: shift in the next dividend bit, trial
// subtract the divisor magnitude, keep the difference if it did not borrow.
module div_step
  import div_pkg::*;
(
  input  logic [REM_W-1:0] i_rem,
  input  logic [REM_W-1:0] i_dvs,
  input  logic             i_bit,
  output logic [REM_W-1:0] o_rem,
  output logic             o_qbit
);

  logic [REM_W:0] w_shift;
  logic [REM_W:0] w_diff;

  // trial subtract carried out one bit wider so the borrow is never lost
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {1'b0, i_dvs};
    o_qbit  = ~w_diff[REM_W];
    o_rem   = w_diff[REM_W] ? w_shift[REM_W-1:0] : w_diff[REM_W-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential signed 32/16 divider with fixed 18-cycle latency.
// The high dividend half seeds the partial remainder, so only the low 16
// bits are shifted through; a high half >= divisor can only mean overflow.
module seq_div
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  seq_div_if.slave   bus,
  output div_state_e o_dbg_state
);

  div_state_e       r_state;
  div_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DVD_W-1:0] r_dvd;
  logic [DVS_W-1:0] r_dvs;
  logic [DVS_W-1:0] r_low;
  logic [REM_W-1:0] r_rem;
  logic [REM_W-1:0] r_dvs_mag;
  logic [QUO_W-1:0] r_quo;
  logic             r_res_neg;
  logic             r_rem_neg;
  logic             r_dz;
  logic             r_range;
  logic [QUO_W-1:0] r_quotient;
  logic [QUO_W-1:0] r_remainder;
  logic             r_div_zero;
  logic             r_overflow;

  logic [DVD_W-1:0] w_dvd_mag;
  logic [REM_W-1:0] w_dvs_mag;
  logic [REM_W-1:0] w_rem_nxt;
  logic             w_qbit;
  logic             w_ovf;
  logic [QUO_W-1:0] w_q_fix;
  logic [QUO_W-1:0] w_r_fix;

  div_step u_step (
    .i_rem  (r_rem),
    .i_dvs  (r_dvs_mag),
    .i_bit  (r_low[DVS_W-1]),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_PREP;
      S_PREP:  w_next = S_ITER;
      S_ITER:  if (r_cnt == CNT_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // operand magnitudes; -2^31 and -2^15 negate to themselves as unsigned
  always_comb begin
    w_dvd_mag = r_dvd[DVD_W-1] ? -r_dvd : r_dvd;
    w_dvs_mag = r_dvs[DVS_W-1] ? {1'b0, -r_dvs} : {1'b0, r_dvs};
  end

  // sign restoration and range test on the unsigned quotient
  always_comb begin
    w_q_fix = r_res_neg ? -r_quo : r_quo;
    w_r_fix = r_rem_neg ? -r_rem[QUO_W-1:0] : r_rem[QUO_W-1:0];
    w_ovf   = r_range
            | (~r_res_neg & (r_quo > QUO_POS_MAX))
            | ( r_res_neg & (r_quo > QUO_NEG_MAX));
  end

  // operand capture, preparation and iteration datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_low     <= '0;
      r_rem     <= '0;
      r_dvs_mag <= '0;
      r_quo     <= '0;
      r_res_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_dz      <= 1'b0;
      r_range   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dvd <= bus.dividend;
            r_dvs <= bus.divisor;
          end
        end
        S_PREP: begin
          r_low     <= w_dvd_mag[DVS_W-1:0];
          r_rem     <= {1'b0, w_dvd_mag[DVD_W-1:DVS_W]};
          r_dvs_mag <= w_dvs_mag;
          r_res_neg <= r_dvd[DVD_W-1] ^ r_dvs[DVS_W-1];
          r_rem_neg <= r_dvd[DVD_W-1];
          r_dz      <= (r_dvs == '0);
          r_range   <= ({1'b0, w_dvd_mag[DVD_W-1:DVS_W]} >= w_dvs_mag);
          r_quo     <= '0;
          r_cnt     <= '0;
        end
        S_ITER: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[QUO_W-2:0], w_qbit};
          r_low <= {r_low[DVS_W-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // result registers, loaded only on the FIX->DONE edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (r_state == S_FIX) begin
      r_div_zero <= r_dz;
      r_overflow <= ~r_dz & w_ovf;
      if (r_dz || w_ovf) begin
        r_quotient  <= '0;
        r_remainder <= '0;
      end else begin
        r_quotient  <= w_q_fix;
        r_remainder <= w_r_fix;
      end
    end
  end

  assign bus.busy      = (r_state == S_PREP) || (r_state == S_ITER) || (r_state == S_FIX);
  assign bus.done      = (r_state == S_DONE);
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.div_zero  = r_div_zero;
  assign bus.overflow  = r_overflow;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: vector table plus hand-written reset/busy/back-to-back sequences.
module tb_seq_div;
  import div_pkg::*;

  logic       clk;
  logic       rst;
  div_state_e dbg_state;
  int         pass_cnt;
  int         total_cnt;

  seq_div_if bus ();

  seq_div u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  // called #1 after the accepting edge; counts edges until done is seen
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_div(input logic [31:0] dvd, input logic [15:0] dvs,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output logic ov, output int lat,
                         output logic busy_acc, output logic busy_done,
                         output logic done_next);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = 16'($urandom);
    busy_acc = bus.busy;
    wait_done(lat);
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_zero;
    ov = bus.overflow;
    busy_done = bus.busy;
    @(posedge clk); #1;
    done_next = bus.done;
  endtask

  initial begin
    logic [15:0] q, r;
    logic        dz, ov, busy_acc, busy_done, done_next;
    int          lat;
    int          done_seen;

    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0]  = '{32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF_FF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
    vecs[2]  = '{32'h0000_0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
    vecs[3]  = '{32'hFFFF_FF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{32'hFFFF_8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000_8000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[6]  = '{32'h0001_0000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[7]  = '{32'h0000_3039, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{32'hFFFF_CFC7, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{32'h8000_0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{32'h8000_0000, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{32'hC000_0000, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[12] = '{32'hC000_0000, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[13] = '{32'h0000_0000, 16'hFFFB, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{32'h0000_0007, 16'h0064, 16'h0000, 16'h0007, 1'b0, 1'b0};
    vecs[15] = '{32'hFFFF_FFF9, 16'h0064, 16'h0000, 16'hFFF9, 1'b0, 1'b0};
    vecs[16] = '{32'h000F_4240, 16'h03E8, 16'h03E8, 16'h0000, 1'b0, 1'b0};
    vecs[17] = '{32'h000F_4240, 16'h03E7, 16'h03E9, 16'h0001, 1'b0, 1'b0};
    vecs[18] = '{32'h7FFF_FFFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[19] = '{32'h3FFF_0006, 16'h7FFF, 16'h7FFF, 16'h0005, 1'b0, 1'b0};
    vecs[20] = '{32'hC000_8000, 16'h7FFF, 16'h8000, 16'h0000, 1'b0, 1'b0};
    vecs[21] = '{32'hC000_7FFD, 16'h7FFF, 16'h8000, 16'hFFFD, 1'b0, 1'b0};
    vecs[22] = '{32'h0000_8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b0};
    vecs[23] = '{32'hFFFF_7FFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1};

    // reset
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_q",     32'(bus.quotient), 32'd0);
    check("rst_r",     32'(bus.remainder), 32'd0);
    check("rst_dz",    32'(bus.div_zero), 32'd0);
    check("rst_ov",    32'(bus.overflow), 32'd0);

    // vector table
    for (int i = 0; i < NVEC; i++) begin
      run_div(vecs[i].dvd, vecs[i].dvs, q, r, dz, ov, lat, busy_acc, busy_done, done_next);
      check($sformatf("v%0d_lat", i),       32'(lat), 32'd18);
      check($sformatf("v%0d_busy_acc", i),  32'(busy_acc), 32'd1);
      check($sformatf("v%0d_busy_done", i), 32'(busy_done), 32'd0);
      check($sformatf("v%0d_done_len", i),  32'(done_next), 32'd0);
      check($sformatf("v%0d_q", i),         32'(q), 32'(vecs[i].q));
      check($sformatf("v%0d_r", i),         32'(r), 32'(vecs[i].r));
      check($sformatf("v%0d_dz", i),        32'(dz), 32'(vecs[i].dz));
      check($sformatf("v%0d_ov", i),        32'(ov), 32'(vecs[i].ov));
    end

    // start re-pulsed while busy and in DONE is ignored; start after done accepted
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= 3 && lat <= 5) begin
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 16'd5;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("busy_ign_lat", 32'(lat), 32'd18);
    check("busy_ign_q",   32'(bus.quotient), 32'h000E);
    check("busy_ign_r",   32'(bus.remainder), 32'h0002);
    bus.start = 1'b1; bus.dividend = 32'hFFFF_FF9C; bus.divisor = 16'd7;
    @(posedge clk); #1;
    check("done_start_ign_busy",  32'(bus.busy), 32'd0);
    check("done_start_ign_state", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = 32'd1; bus.divisor = 16'd1;
    check("b2b_accept", 32'(bus.busy), 32'd1);
    wait_done(lat);
    check("b2b_lat", 32'(lat), 32'd18);
    check("b2b_q",   32'(bus.quotient), 32'hFFF2);
    check("b2b_r",   32'(bus.remainder), 32'hFFFE);

    // reset at iteration 8 discards the operation
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_iter_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy",  32'(bus.busy), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("mid_rst_q",     32'(bus.quotient), 32'd0);
    check("mid_rst_r",     32'(bus.remainder), 32'd0);
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("mid_rst_no_done", 32'(done_seen), 32'd0);

    // reset beats start in the same cycle
    bus.start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; rst = 1'b0;
    check("rst_prio_busy", 32'(bus.busy), 32'd0);

    // fresh operation after reset
    run_div(32'd1000, 16'd7, q, r, dz, ov, lat, busy_acc, busy_done, done_next);
    check("post_rst_lat", 32'(lat), 32'd18);
    check("post_rst_q",   32'(q), 32'h008E);
    check("post_rst_r",   32'(r), 32'h0006);
    check("post_rst_dz",  32'(dz), 32'd0);
    check("post_rst_ov",  32'(ov), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 No parameters; operand widths fixed at 32-bit dividend, 16-bit divisor.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 dividend  input  32  signed two's-complement; latched when start accepted.
REQ-006 divisor  input  16  signed two's-complement; latched when start accepted.
REQ-007 busy  output  1  high from the edge accepting start until the edge entering DONE.
REQ-008 done  output  1  one-cycle pulse; results valid while high and held until next accept.
REQ-009 quotient  output  16  signed quotient, truncated toward zero.
REQ-010 remainder  output  16  signed remainder, sign equals dividend sign (or zero).
REQ-011 div_zero  output  1  divisor was zero.
REQ-012 overflow  output  1  quotient not representable in 16-bit signed.

Function
REQ-013 FSM states IDLE, PREP, ITER, FIX, DONE; IDLE->PREP on start; PREP->ITER; ITER->FIX after 16 iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-014 PREP: form 32-bit magnitude of dividend, 16-bit magnitude of divisor (17-bit internal), record result sign (dividend XOR divisor sign) and remainder sign (dividend sign).
REQ-015 PREP: div_zero flag set if divisor==0; range flag set if magnitude[31:16] >= divisor magnitude.
REQ-016 ITER: restoring unsigned step per cycle, one quotient bit per cycle MSB first, 4-bit counter 0..15.
REQ-017 Partial remainder held 17 bits wide; trial subtract in 17 bits, no truncation of carry.
REQ-018 FIX: negate quotient if result sign set, negate remainder if remainder sign set; overflow if range flag set, or unsigned quotient > 32767 with positive result, or > 32768 with negative result.
REQ-019 Fixed latency: start sampled at edge N -> done high in the cycle after edge N+18, for exactly one cycle; same latency for div_zero and overflow cases.
REQ-020 On div_zero or overflow: quotient=16'h0000, remainder=16'h0000; div_zero has priority (overflow=0 when div_zero=1).
REQ-021 Outputs quotient, remainder, div_zero, overflow registered; updated only at FIX->DONE edge; held otherwise.
REQ-022 start while busy or in DONE is ignored; operand input changes after accept have no effect.
REQ-023 Back-to-back: start high in the cycle after done is accepted (IDLE reached at edge N+19).
REQ-024 Dividend -2^31 handled: magnitude 32'h8000_0000 represented exactly.

Reset
REQ-025 rst high at any edge, including mid-ITER: next state IDLE, counter 0, busy=0, done=0, quotient=0, remainder=0, div_zero=0, overflow=0.
REQ-026 rst takes priority over start in the same cycle; an operation in progress is discarded with no done pulse.

Structure
REQ-027 Package div_pkg holds the state enum, ITER_CNT=16, and operand width constants.
REQ-028 One sub-module div_step: combinational restoring step (17-bit partial remainder, divisor magnitude, next dividend bit -> next remainder, quotient bit).
REQ-029 FSM, counter, sign handling, and output registers reside in seq_div.

Verification
REQ-030 100 / 7 -> quotient=14, remainder=2, flags 0, done exactly 18 cycles after start edge, busy low on the done cycle.
REQ-031 -100 / 7 -> quotient=16'hFFF2, remainder=16'hFFFE; 100 / -7 -> quotient=16'hFFF2, remainder=2.
REQ-032 32'hFFFF_8000 / 1 -> quotient=16'h8000, overflow=0; 32'h0000_8000 / 1 -> overflow=1, quotient=0; 32'h0001_0000 / 1 -> overflow=1.
REQ-033 12345 / 0 -> div_zero=1, overflow=0, quotient=0, remainder=0, same 18-cycle latency.
REQ-034 rst pulsed at cycle 8 of ITER -> busy=0 next cycle, no done pulse; a new start then gives a correct result.
REQ-035 start re-pulsed while busy with different operands -> ignored, first result unchanged; start in the cycle after done -> accepted.
